// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule: loads the round-10 key and steps backward one
// round per accepted beat, presenting round keys 10 down to 0.
module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic [127:0] last_key_in,
  input  logic         ready_in,
  output logic [127:0] round_key_out,
  output logic [3:0]   round_idx_out,
  output logic         key_valid_out,
  output logic         busy_out,
  output logic         done_out
);

  // Handshake: a beat happens on a rising edge where key_valid_out & ready_in;
  // round_key_out/round_idx_out are held stable while valid and not ready.

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Undo the forward recurrence: recover w1..w3 first, then w0 needs w3 of the
  // previous round, which is exactly the recovered w3'.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n, rot_w, sub_w;
  logic [127:0] prev_key;

  always_comb begin
    {w0, w1, w2, w3} = key_q;
    w3_n  = w3 ^ w2;
    w2_n  = w2 ^ w1;
    w1_n  = w1 ^ w0;
    rot_w = {w3_n[23:0], w3_n[31:24]};
    sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
    w0_n  = w0 ^ sub_w ^ {rcon(idx_q), 24'h0};
    prev_key = {w0_n, w1_n, w2_n, w3_n};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        // The done cycle still belongs to the finishing run, so no restart then.
        if (start_in && !done_q) begin
          key_d   = last_key_in;
          idx_d   = 4'(NR);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ready_in) begin
          if (idx_q == 4'd0) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            key_d = prev_key;
            idx_d = idx_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign round_key_out = key_q;
  assign round_idx_out = idx_q;
  assign key_valid_out = valid_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: expected round keys come from a forward AES-128
// key expansion whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in;
  logic [127:0] last_key_in;
  logic         ready_in;
  logic [127:0] round_key_out;
  logic [3:0]   round_idx_out;
  logic         key_valid_out;
  logic         busy_out;
  logic         done_out;

  aes_inv_key_sched #(.NR(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .last_key_in   (last_key_in),
    .ready_in      (ready_in),
    .round_key_out (round_key_out),
    .round_idx_out (round_idx_out),
    .key_valid_out (key_valid_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb[256];
  logic [127:0] rk[11];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = key;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_expected(input logic [127:0] key);
    expand(key);
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back(rk[r]);
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [127:0] k);
    start_in    = 1'b1;
    last_key_in = k;
    step();
    start_in    = 1'b0;
    last_key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Walks the sequence from the idx-10 cycle to the done cycle, consuming exp_q.
  task automatic run_keys(input int bp_idx, input int bp_len, input bit rnd,
                          input int busy_start_idx, input logic [127:0] busy_key);
    int exp_idx = 10;
    int bp_left = bp_len;
    int guard = 0;
    bit fin = 1'b0;
    while (!fin && guard < 200) begin
      guard++;
      check("run_valid", key_valid_out, 1);
      check("run_busy", busy_out, 1);
      check("run_done_low", done_out, 0);
      check("run_key", round_key_out, exp_q.size() > 0 ? exp_q[0] : 'x);
      check("run_idx", round_idx_out, exp_idx);
      ready_in = 1'b1;
      if (rnd) ready_in = 1'($urandom_range(0, 1));
      if (exp_idx == bp_idx && bp_left > 0) begin
        ready_in = 1'b0;
        bp_left--;
      end
      start_in = (exp_idx == busy_start_idx);
      if (start_in) last_key_in = busy_key;
      step();
      start_in = 1'b0;
      if (ready_in) begin
        void'(exp_q.pop_front());
        if (exp_idx == 0) fin = 1'b1;
        else exp_idx--;
      end
    end
    check("run_timeout", fin, 1);
    check("done_pulse", done_out, 1);
    check("done_valid_low", key_valid_out, 0);
    check("done_busy_low", busy_out, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    rst = 1'b1; start_in = 1'b0; ready_in = 1'b0; last_key_in = '0;
    step();
    step();
    check("rst_key", round_key_out, 0);
    check("rst_idx", round_idx_out, 0);
    check("rst_valid", key_valid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    rst = 1'b0;
    step();
    check("idle_valid", key_valid_out, 0);

    // FIPS-197 A.1 with ready tied high
    load_expected(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("a1_idx9_model", exp_q[1], 128'hac7766f319fadc2128d12941575c006e);
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_keys(-1, 0, 1'b0, -1, '0);
    check("a1_final_key", round_key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    step();
    check("a1_done_clear", done_out, 0);
    check("a1_key_keep", round_key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Backpressure at idx 9 for 3 cycles
    load_expected(128'h2b7e151628aed2a6abf7158809cf4f3c);
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_keys(9, 3, 1'b0, -1, '0);
    step();

    // Start while busy is ignored
    load_expected(128'h2b7e151628aed2a6abf7158809cf4f3c);
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_keys(5, 0, 1'b0, 5, 128'h00112233445566778899aabbccddeeff);
    check("busy_start_final", round_key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    step();

    // Zero cipher key
    load_expected('0);
    start_seq(128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    run_keys(-1, 0, 1'b0, -1, '0);
    check("zero_final", round_key_out, 0);
    step();

    // Reset mid-sequence at idx 4
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    ready_in = 1'b1;
    for (int g = 0; g < 20 && round_idx_out != 4'd4; g++) step();
    check("rstmid_reach_idx4", round_idx_out, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_key", round_key_out, 0);
    check("rstmid_idx", round_idx_out, 0);
    check("rstmid_valid", key_valid_out, 0);
    check("rstmid_busy", busy_out, 0);
    check("rstmid_done", done_out, 0);
    for (int g = 0; g < 3; g++) begin
      step();
      check("rstmid_no_done", done_out, 0);
      check("rstmid_idle", key_valid_out, 0);
    end
    load_expected(128'h2b7e151628aed2a6abf7158809cf4f3c);
    start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_keys(-1, 0, 1'b0, -1, '0);

    // Back-to-back: start in the done cycle ignored, next cycle accepted
    k = {$urandom, $urandom, $urandom, $urandom};
    load_expected(k);
    start_in    = 1'b1;
    last_key_in = exp_q[0];
    step();
    check("b2b_ignored_valid", key_valid_out, 0);
    check("b2b_ignored_busy", busy_out, 0);
    step();
    start_in = 1'b0;
    check("b2b_accept_idx", round_idx_out, 10);
    run_keys(-1, 0, 1'b0, -1, '0);
    check("b2b_final", round_key_out, k);
    step();

    // Random cipher keys with random backpressure
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_expected(k);
      start_seq(exp_q[0]);
      run_keys(-1, 0, 1'b1, -1, '0);
      check("rand_final", round_key_out, k);
      repeat ($urandom_range(1, 3)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
